// File: rtl/vec_pkg.sv
// ============================================================================
// Module      : vec_pkg
// Description : Shared sizes, limits and FSM state type for the vector-add
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vec_pkg;

    localparam int VLEN    = 16;
    localparam int EW      = 16;
    localparam int IDXW    = 4;
    localparam int TIMEOUT = 48;

    localparam int CNTW = $clog2(VLEN + 1);
    localparam int TMRW = $clog2(TIMEOUT + 1);

    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(VLEN);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(VLEN - 1);
    // Timer value seen in the last cycle before the timeout fires
    localparam logic [TMRW-1:0] TMR_LAST = TMRW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_WAITDONE = 2'd2,
        S_FINISH   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/vec_add_sequencer.sv
// ============================================================================
// Module      : vec_add_sequencer
// Description : Drives a serial adder over one 16-element vector and writes
//               each returned sum to the destination register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_add_sequencer
    import vec_pkg::*;
(
    input  logic            Clk,
    input  logic            Rst,
    input  logic            go,
    output logic            busy,
    output logic            finish,
    output logic            ovf,
    output logic            err,
    output logic [IDXW-1:0] rd_idx,
    input  logic [EW-1:0]   ra_data,
    input  logic [EW-1:0]   rb_data,
    output logic [EW-1:0]   A,
    output logic [EW-1:0]   B,
    output logic            start,
    input  logic            write,
    input  logic            done,
    input  logic [EW-1:0]   SumV,
    input  logic            V,
    output logic            wr_en,
    output logic [IDXW-1:0] wr_idx,
    output logic [EW-1:0]   wr_data
);

    state_t          state_q,   state_d;
    logic [IDXW-1:0] rd_idx_q,  rd_idx_d;
    logic [CNTW-1:0] count_q,   count_d;
    logic [TMRW-1:0] timer_q,   timer_d;
    logic            ovf_q,     ovf_d;
    logic            err_q,     err_d;
    logic            wr_en_q,   wr_en_d;
    logic [IDXW-1:0] wr_idx_q,  wr_idx_d;
    logic [EW-1:0]   wr_data_q, wr_data_d;

    logic active;
    logic capture;

    assign active  = (state_q == S_RUN) || (state_q == S_WAITDONE);
    // done takes priority over a coincident write
    assign capture = active && write && !done && (count_q < CNT_FULL);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            rd_idx_q  <= '0;
            count_q   <= '0;
            timer_q   <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_idx_q  <= rd_idx_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_idx_d  = rd_idx_q;
        count_d   = count_q;
        timer_d   = timer_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d  = S_RUN;
                    rd_idx_d = '0;
                    count_d  = '0;
                    timer_d  = '0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                end
            end
            S_RUN, S_WAITDONE: begin
                timer_d = timer_q + 1'b1;
                if ((state_q == S_RUN) && (rd_idx_q != IDX_LAST)) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                end
                if (capture) begin
                    wr_en_d   = 1'b1;
                    wr_idx_d  = count_q[IDXW-1:0];
                    wr_data_d = SumV;
                    count_d   = count_q + 1'b1;
                end
                if (done) begin
                    state_d = S_FINISH;
                    ovf_d   = V;
                    err_d   = (count_q < CNT_FULL);
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_FINISH;
                    err_d   = 1'b1;
                end else if ((state_q == S_RUN) && (count_d == CNT_FULL)) begin
                    state_d = S_WAITDONE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = active;
    assign start   = active;
    assign finish  = (state_q == S_FINISH);
    assign ovf     = ovf_q;
    assign err     = err_q;
    assign rd_idx  = rd_idx_q;
    assign A       = ra_data;
    assign B       = rb_data;
    assign wr_en   = wr_en_q;
    assign wr_idx  = wr_idx_q;
    assign wr_data = wr_data_q;

endmodule

`default_nettype wire

// File: tb/tb_vec_add_sequencer.sv
// ============================================================================
// Module      : tb_vec_add_sequencer
// Description : Randomized self-checking bench with a behavioural adder and
//               destination-write model for vec_add_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vec_add_sequencer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        go;
    logic        busy, finish, ovf, err, start, wr_en;
    logic [3:0]  rd_idx, wr_idx;
    logic [15:0] ra_data, rb_data, A, B, SumV, wr_data;
    logic        write, done, V;

    logic [15:0] a_mem [16];
    logic [15:0] b_mem [16];

    int n_vec = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    always_comb begin
        ra_data = a_mem[rd_idx];
        rb_data = b_mem[rd_idx];
    end

    vec_add_sequencer dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .go      (go),
        .busy    (busy),
        .finish  (finish),
        .ovf     (ovf),
        .err     (err),
        .rd_idx  (rd_idx),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .A       (A),
        .B       (B),
        .start   (start),
        .write   (write),
        .done    (done),
        .SumV    (SumV),
        .V       (V),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] sum16(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'(a) + int'(b);
        return 16'(s);
    endfunction

    function automatic bit ovf16(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        return (s > 32767) || (s < -32768);
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) begin
            a_mem[i] = 16'($urandom);
            b_mem[i] = 16'($urandom);
        end
    endtask

    // One operation: build an adder schedule, predict the outcome, then drive and compare.
    task automatic run_op(input int n_wr, input bit with_done, input bit gaps,
                          input bit done_wr, input bit go_spam, input int rst_at);
        bit          sw [64];
        bit          sd [64];
        bit          vd [64];
        logic [15:0] sv [64];
        bit          ew [64];
        logic [3:0]  ei [64];
        logic [15:0] ed [64];
        int          fin, cap, k, c, placed, ri;
        bit          e_err, e_ovf, vacc;

        for (int i = 0; i < 64; i++) begin
            sw[i] = 1'b0; sd[i] = 1'b0; vd[i] = 1'b0; sv[i] = 16'($urandom);
            ew[i] = 1'b0; ei[i] = 4'd0; ed[i] = 16'd0;
        end
        placed = 0;
        c = 0;
        while (placed < n_wr && c < 44) begin
            if (!(gaps && $urandom_range(2) == 0)) begin
                sw[c] = 1'b1;
                placed++;
            end
            c++;
        end
        if (with_done) begin
            if (gaps) c = c + int'($urandom_range(2));
            sd[c] = 1'b1;
            if (done_wr) sw[c] = 1'b1;
        end

        fin = 48; e_err = 1'b1; e_ovf = 1'b0; cap = 0; k = 0; vacc = 1'b0;
        for (int i = 0; i < 48; i++) begin
            vd[i] = vacc;
            if (sd[i]) begin
                fin = i + 1;
                e_err = (cap < 16);
                e_ovf = vacc;
                break;
            end
            if (sw[i]) begin
                sv[i] = sum16(a_mem[k % 16], b_mem[k % 16]);
                if (cap < 16) begin
                    ew[i+1] = 1'b1;
                    ei[i+1] = 4'(cap);
                    ed[i+1] = sv[i];
                    cap++;
                end
                if (ovf16(a_mem[k % 16], b_mem[k % 16])) vacc = 1'b1;
                k++;
            end
        end

        go = 1'b1;
        @(posedge Clk); #1;
        go = 1'b0;
        for (int cc = 0; cc <= fin + 1; cc++) begin
            write = (cc < fin) ? sw[cc] : 1'b0;
            done  = (cc < fin) ? sd[cc] : 1'b0;
            V     = (cc < fin) ? vd[cc] : 1'b0;
            SumV  = sv[cc];
            go    = (go_spam && cc <= fin) ? 1'($urandom_range(1)) : 1'b0;
            @(negedge Clk);
            check("busy",   32'(busy),   32'(cc < fin));
            check("start",  32'(start),  32'(cc < fin));
            check("finish", 32'(finish), 32'(cc == fin));
            check("wr_en",  32'(wr_en),  32'(ew[cc]));
            if (ew[cc]) begin
                check("wr_idx",  32'(wr_idx),  32'(ei[cc]));
                check("wr_data", 32'(wr_data), 32'(ed[cc]));
            end
            if (cc <= fin) begin
                ri = (cc > 15) ? 15 : cc;
                check("rd_idx", 32'(rd_idx), 32'(ri));
                check("A",      32'(A),      32'(a_mem[ri]));
                check("B",      32'(B),      32'(b_mem[ri]));
            end
            if (cc == fin) begin
                check("err", 32'(err), 32'(e_err));
                check("ovf", 32'(ovf), 32'(e_ovf));
            end
            if (cc == rst_at) begin
                #1;
                Rst = 1'b1; write = 1'b0; done = 1'b0; go = 1'b0;
                #1;
                check("rst_abort", 32'({busy, start, finish, ovf, err, wr_en, wr_idx, wr_data, rd_idx}), 32'd0);
                @(posedge Clk); #1;
                check("rst_quiet", 32'({finish, wr_en, busy}), 32'd0);
                @(negedge Clk);
                Rst = 1'b0;
                break;
            end
            @(posedge Clk); #1;
        end
        go = 1'b0; write = 1'b0; done = 1'b0; V = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        Rst = 1'b1; go = 1'b0; write = 1'b0; done = 1'b0; V = 1'b0; SumV = 16'd0;
        fill_rand();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_outs", 32'({busy, start, finish, ovf, err, wr_en, wr_idx, wr_data, rd_idx}), 32'd0);
        Rst = 1'b0;
        @(posedge Clk); #1;

        for (int i = 0; i < 16; i++) begin a_mem[i] = 16'h9939; b_mem[i] = 16'h9939; end
        check("model_9939", 32'(sum16(16'h9939, 16'h9939)), 32'h3272);
        run_op(16, 1'b1, 1'b0, 1'b0, 1'b0, -1);

        for (int i = 0; i < 16; i++) begin a_mem[i] = 16'(i); b_mem[i] = 16'h0100; end
        run_op(16, 1'b1, 1'b0, 1'b0, 1'b0, -1);

        fill_rand();
        run_op(5, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        run_op(16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_op(16, 1'b1, 1'b0, 1'b0, 1'b0, 8);
        run_op(16, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        run_op(16, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        run_op(20, 1'b1, 1'b1, 1'b1, 1'b0, -1);
        run_op(10, 1'b1, 1'b1, 1'b1, 1'b1, -1);

        for (int t = 0; t < 8; t++) begin
            fill_rand();
            run_op(int'($urandom_range(20, 4)), ($urandom_range(3) != 0), 1'b1,
                   1'($urandom_range(1)), 1'($urandom_range(1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vec_add_sequencer.md
VEC_ADD_SEQUENCER -- requirements
Module: vec_add_sequencer

Interface
REQ-001 Clk  in  1  single system clock; all state updates on posedge Clk.
REQ-002 Rst  in  1  asynchronous, active-high reset.
REQ-003 go  in  1  one-cycle request to run one 16-element vector add; sampled only in IDLE.
REQ-004 busy  out  1  high from the cycle after an accepted go until finish.
REQ-005 finish  out  1  one-cycle pulse: operation ended, ovf/err valid.
REQ-006 ovf  out  1  sticky overflow from the adder V, held until next accepted go.
REQ-007 err  out  1  protocol/timeout error flag, held until next accepted go.
REQ-008 rd_idx  out  4  element index to the source vector register file.
REQ-009 ra_data, rb_data  in  16 each  combinational read data for rd_idx.
REQ-010 A, B  out  16 each  operands to the serial adder; A=ra_data, B=rb_data, combinational pass-through.
REQ-011 start  out  1  adder run request; held high for the whole operation.
REQ-012 write, done  in  1 each  adder result-valid and completion indications.
REQ-013 SumV  in  16  adder element result; V  in  1  adder overflow.
REQ-014 wr_en  out  1  registered destination write strobe.
REQ-015 wr_idx  out  4  registered destination element index.
REQ-016 wr_data  out  16  registered destination data.

Function
REQ-017 FSM states: IDLE, RUN, WAITDONE, FINISH; encoding from the shared package.
REQ-018 IDLE: go=1 -> RUN; rd_idx<=0, ovf<=0, err<=0, capture count<=0, timer<=0.
REQ-019 RUN/WAITDONE: start=1; rd_idx increments by 1 per cycle in RUN, saturates at 15, never wraps.
REQ-020 Capture: in RUN/WAITDONE, each cycle with write=1, done=0 and count<16 -> next cycle wr_en=1, wr_idx=count, wr_data=SumV; count+1.
REQ-021 Once count reaches 16, further write pulses are ignored; no wr_en.
REQ-022 RUN -> WAITDONE when count reaches 16.
REQ-023 done=1 in RUN or WAITDONE -> FINISH; ovf<=V (V is sticky in the adder); err<=1 when count<16 at that cycle.
REQ-024 Timeout: timer counts cycles since leaving IDLE; reaching TIMEOUT (48) without done -> FINISH with err=1.
REQ-025 FINISH: start=0, finish=1 for exactly one cycle, busy=0; next state IDLE.
REQ-026 A new go is ignored while busy; a go arriving in the FINISH cycle is ignored.
REQ-027 Simultaneous done and write in one cycle: done wins; that write is not captured.
REQ-028 Minimum spacing between go acceptances is 2 cycles after finish, giving the adder one start-low cycle to clear.

Reset
REQ-029 On Rst: state=IDLE, start=0, busy=0, finish=0, ovf=0, err=0, wr_en=0, wr_idx=0, wr_data=0, rd_idx=0, count=0, timer=0.
REQ-030 Rst asserted mid-operation aborts immediately; no finish pulse; no further wr_en.

Structure
REQ-031 Shared package vec_pkg holds VLEN=16, EW=16, IDXW=4, TIMEOUT=48 and the FSM state type.
REQ-032 No sub-module; the serial adder is instantiated beside this block, not inside it.

Verification
REQ-033 All elements 0x9939+0x9939 -> 16 wr_en pulses, wr_idx 0..15, wr_data=0x3272, ovf=1, err=0, one finish.
REQ-034 A[i]=i, B[i]=0x0100 -> wr_data[i]=0x0100+i, ovf=0.
REQ-035 done forced after 5 writes -> finish with err=1, only 5 wr_en pulses.
REQ-036 done never asserted -> finish exactly 48 cycles after go acceptance, err=1, start drops.
REQ-037 Rst pulsed at capture 8 -> all outputs zero at once, no finish; next go runs cleanly.
REQ-038 go repeated while busy -> ignored; exactly one finish pulse.
